// File: rtl/ahb_lite_sram_slave_pkg.sv
// rtl/ahb_lite_sram_slave_pkg.sv - shared AHB-Lite encodings and slave FSM states
package ahb_lite_sram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

endpackage

// File: rtl/ahb_lite_byte_strobe.sv
// rtl/ahb_lite_byte_strobe.sv - size/addr[1:0] to little-endian byte enables plus alignment error
module ahb_lite_byte_strobe
    import ahb_lite_sram_slave_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb,
    output logic       align_err
);

    always_comb begin
        strb      = 4'b0000;
        align_err = 1'b0;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                strb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                align_err = addr_lo[0];
            end
            HSIZE_WORD: begin
                strb      = 4'b1111;
                align_err = |addr_lo;
            end
            // oversize transfers share the alignment error path
            default:    align_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite SRAM slave with byte lanes, wait states and ERROR response
module ahb_lite_sram_slave
    import ahb_lite_sram_slave_pkg::*;
#(
    parameter int BUS_WIDTH   = 32,
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 0
)
(
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HSEL,
    input  logic [BUS_WIDTH-1:0] HADDR,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [2:0]           HBURST,
    input  logic [3:0]           HPROT,
    input  logic [1:0]           HTRANS,
    input  logic                 HMASTLOCK,
    input  logic [BUS_WIDTH-1:0] HWDATA,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [BUS_WIDTH-1:0] HRDATA
);

    localparam int         IDX_W = $clog2(MEM_WORDS);
    localparam int         LANES = BUS_WIDTH / 8;
    localparam logic [1:0] WS    = WAIT_STATES[1:0];

    logic [BUS_WIDTH-1:0] mem [MEM_WORDS];

    logic [2:0]           state, next_state;
    logic [1:0]           cnt, next_cnt;
    logic [IDX_W-1:0]     cap_idx;
    logic                 cap_write;
    logic [3:0]           cap_strb;

    logic                 accept;
    logic [3:0]           strb;
    logic                 align_err;
    logic                 out_of_range;
    logic                 phase_err;
    logic [IDX_W-1:0]     addr_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic [BUS_WIDTH-1:0] wr_word;
    logic [BUS_WIDTH-1:0] rd_word;
    logic                 load_rd;
    logic                 unused_ok;

    assign unused_ok = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

    ahb_lite_byte_strobe u_strobe (
        .size      (HSIZE),
        .addr_lo   (HADDR[1:0]),
        .strb      (strb),
        .align_err (align_err)
    );

    // HREADYOUT low means we still own the data phase, so no new phase can be taken
    assign accept       = HSEL && HREADY && HTRANS[1] && HREADYOUT;
    assign addr_idx     = HADDR[IDX_W+1:2];
    assign out_of_range = |HADDR[BUS_WIDTH-1:IDX_W+2];
    assign phase_err    = align_err || out_of_range;

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            ST_WAIT: begin
                if (cnt == 2'd1) next_state = ST_DATA;
                else             next_cnt   = cnt - 2'd1;
            end
            ST_ERR1: next_state = ST_ERR2;
            default: begin
                if (!accept) begin
                    next_state = ST_IDLE;
                end else if (phase_err) begin
                    next_state = ST_ERR1;
                end else if (WS != 2'd0) begin
                    next_state = ST_WAIT;
                    next_cnt   = WS;
                end else begin
                    next_state = ST_DATA;
                end
            end
        endcase
    end

    always_comb begin
        wr_word = mem[cap_idx];
        for (int i = 0; i < LANES; i++) begin
            if (cap_strb[i]) wr_word[8*i +: 8] = HWDATA[8*i +: 8];
        end
    end

    // A read taken during a completing write to the same word sees the merged bytes
    assign rd_idx  = (state == ST_WAIT) ? cap_idx : addr_idx;
    assign rd_word = (state == ST_DATA && cap_write && cap_idx == rd_idx) ? wr_word : mem[rd_idx];
    assign load_rd = (next_state == ST_DATA) && !(accept ? HWRITE : cap_write);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            cnt       <= 2'd0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= '0;
            cap_idx   <= '0;
            cap_write <= 1'b0;
            cap_strb  <= 4'b0000;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            HREADYOUT <= (next_state != ST_WAIT) && (next_state != ST_ERR1);
            HRESP     <= (next_state == ST_ERR1 || next_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
            if (accept) begin
                cap_idx   <= addr_idx;
                cap_write <= HWRITE;
                cap_strb  <= strb;
            end
            if (load_rd) HRDATA <= rd_word;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn && state == ST_DATA && cap_write) mem[cap_idx] <= wr_word;
    end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb/tb_ahb_lite_sram_slave.sv - scoreboard bench: two slaves (0 and 2 wait states) behind one master
module tb_ahb_lite_sram_slave;
    import ahb_lite_sram_slave_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        chk;
        logic        resp;
        logic [3:0]  waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sel0, sel1;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        ro0, ro1, rs0, rs1;
    logic [31:0] rd0, rd1;
    logic        dsel;
    logic        hready, hresp;
    logic [31:0] hrdata;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    assign hready = dsel ? ro1 : ro0;
    assign hresp  = dsel ? rs1 : rs0;
    assign hrdata = dsel ? rd1 : rd0;

    ahb_lite_sram_slave #(.BUS_WIDTH(32), .MEM_WORDS(256), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESETn(rstn), .HSEL(sel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(HBURST_SINGLE), .HPROT(4'b0011), .HTRANS(htrans),
        .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hready),
        .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
    );

    ahb_lite_sram_slave #(.BUS_WIDTH(32), .MEM_WORDS(256), .WAIT_STATES(2)) u_ws2 (
        .HCLK(clk), .HRESETn(rstn), .HSEL(sel1), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(HBURST_SINGLE), .HPROT(4'b0011), .HTRANS(htrans),
        .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hready),
        .HREADYOUT(ro1), .HRESP(rs1), .HRDATA(rd1)
    );

    // data-phase owner for the response mux
    always @(posedge clk) begin
        if (!rstn)       dsel <= 1'b0;
        else if (hready) dsel <= sel1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: pops at address-phase accept, compares at data-phase completion
    bit   dphase = 1'b0;
    int   wcnt   = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (!rstn) begin
            dphase = 1'b0;
            wcnt   = 0;
        end else begin
            if (dphase) begin
                if (!hready) begin
                    wcnt++;
                    check("wait_resp", {31'd0, hresp}, {31'd0, cur.resp});
                end else begin
                    check("waits", 32'(wcnt), {28'd0, cur.waits});
                    check("resp", {31'd0, hresp}, {31'd0, cur.resp});
                    if (cur.chk) check("rdata", hrdata, cur.data);
                    dphase = 1'b0;
                end
            end
            if (hready && (sel0 || sel1) && htrans[1]) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_xfer: got accept expected none");
                end else begin
                    cur    = q.pop_front();
                    dphase = 1'b1;
                    wcnt   = 0;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!hready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!hready) begin
            total++;
            bad++;
            $display("FAIL hready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input bit s, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input bit err, input logic [31:0] exp, input int waits);
        q.push_back('{exp, !wr && !err, err, 4'(waits)});
        sel0   = !s;
        sel1   = s;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        htrans = HTRANS_NONSEQ;
        wait_ready();
        hwdata = wd;
    endtask

    task automatic idle(input int n);
        htrans = HTRANS_IDLE;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn   = 1'b0;
        sel0   = 1'b0;
        sel1   = 1'b0;
        haddr  = '0;
        hwdata = '0;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        htrans = HTRANS_IDLE;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_ready0", {31'd0, ro0}, 32'd1);
        check("rst_resp0",  {31'd0, rs0}, 32'd0);
        check("rst_rdata0", rd0, 32'd0);
        check("rst_ready2", {31'd0, ro1}, 32'd1);
        check("rst_resp2",  {31'd0, rs1}, 32'd0);
        check("rst_rdata2", rd1, 32'd0);
        @(posedge clk);
        #1;

        // zero wait: word write then read
        xfer(0, 1, HSIZE_WORD, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0);
        xfer(0, 0, HSIZE_WORD, 32'h10, 32'h0,        0, 32'hDEADBEEF, 0);
        idle(2);

        // byte and half lane merging
        xfer(0, 1, HSIZE_WORD, 32'h10, 32'h00000000, 0, 32'h0, 0);
        xfer(0, 1, HSIZE_BYTE, 32'h11, 32'h0000AA00, 0, 32'h0, 0);
        xfer(0, 0, HSIZE_WORD, 32'h10, 32'h0,        0, 32'h0000AA00, 0);
        xfer(0, 1, HSIZE_HALF, 32'h12, 32'h12340000, 0, 32'h0, 0);
        xfer(0, 0, HSIZE_WORD, 32'h10, 32'h0,        0, 32'h1234AA00, 0);
        idle(2);
        xfer(0, 0, HSIZE_WORD, 32'h10, 32'h0,        0, 32'h1234AA00, 0);
        xfer(0, 0, HSIZE_BYTE, 32'h12, 32'h0,        0, 32'h1234AA00, 0);
        idle(2);

        // forwarding of a completing write into a back-to-back read
        xfer(0, 1, HSIZE_WORD, 32'h20, 32'h11223344, 0, 32'h0, 0);
        xfer(0, 0, HSIZE_WORD, 32'h20, 32'h0,        0, 32'h11223344, 0);
        xfer(0, 1, HSIZE_BYTE, 32'h21, 32'h00005500, 0, 32'h0, 0);
        xfer(0, 0, HSIZE_WORD, 32'h20, 32'h0,        0, 32'h11225544, 0);
        idle(2);

        // error responses leave memory untouched
        xfer(0, 1, HSIZE_WORD, 32'h00,  32'hCAFEF00D, 0, 32'h0, 0);
        xfer(0, 1, HSIZE_WORD, 32'h02,  32'hFFFFFFFF, 1, 32'h0, 1);
        xfer(0, 0, HSIZE_WORD, 32'h400, 32'h0,        1, 32'h0, 1);
        xfer(0, 0, 3'd3,       32'h04,  32'h0,        1, 32'h0, 1);
        xfer(0, 0, HSIZE_WORD, 32'h00,  32'h0,        0, 32'hCAFEF00D, 0);
        idle(3);

        // two wait states
        xfer(1, 1, HSIZE_WORD, 32'h40, 32'hA5A5A5A5, 0, 32'h0, 2);
        xfer(1, 0, HSIZE_WORD, 32'h40, 32'h0,        0, 32'hA5A5A5A5, 2);
        xfer(1, 0, HSIZE_HALF, 32'h41, 32'h0,        1, 32'h0, 1);
        idle(5);

        // reset during a write wait cycle abandons the write
        xfer(1, 1, HSIZE_WORD, 32'h30, 32'h5555AAAA, 0, 32'h0, 2);
        idle(5);
        xfer(1, 1, HSIZE_WORD, 32'h30, 32'h99999999, 0, 32'h0, 2);
        htrans = HTRANS_IDLE;
        rstn   = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check("midrst_ready", {31'd0, ro1}, 32'd1);
        check("midrst_resp",  {31'd0, rs1}, 32'd0);
        check("midrst_rdata0", rd0, 32'd0);
        idle(2);
        xfer(1, 0, HSIZE_WORD, 32'h30, 32'h0, 0, 32'h5555AAAA, 2);
        idle(6);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
